// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame transmitter.
package uart_pkg;

  localparam int FRAME_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // A well-formed frame carries a start bit in bit 0 and a stop bit in bit 9.
  function automatic logic frame_ok(input logic [FRAME_W-1:0] frame);
    return (frame[0] == START_BIT) && (frame[FRAME_W-1] == STOP_BIT);
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Free-running 0..CLKS_PER_BIT-1 counter; tick marks the last cycle of each bit-time.
module baud_counter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else if (en)           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Ready/valid fed UART transmitter: shifts one 10-bit frame LSB-first, then a guard gap.
// Optional frame checking is compiled in with `define UART_TX_FRAME_CHECK_EN.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int GAP_BITS     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ivalid,
  output logic               iready,
  input  logic [FRAME_W-1:0] idata,
  output logic               txd,
  output logic               busy,
  output logic               ferr
);

  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  tx_state_t          state, state_d;
  logic [FRAME_W-1:0] shreg;
  logic [3:0]         bit_idx;
  logic [GW-1:0]      gap_cnt;
  logic               bit_tick;
  logic               accept;
  logic               frame_good;
  logic               load;
  logic               last_bit;
  logic               gap_done;

  assign accept   = ivalid && iready;
  assign last_bit = bit_tick && (bit_idx == 4'd9);
  // Gap length is measured in whole bit-times, accumulated as elapsed cycles.
  assign gap_done = bit_tick && ((int'(gap_cnt) + CLKS_PER_BIT) == GAP_CYCLES);
  assign busy     = (state != IDLE);

`ifdef UART_TX_FRAME_CHECK_EN
  logic ferr_q;
  assign frame_good = frame_ok(idata);
  assign ferr       = ferr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ferr_q <= 1'b0;
    else          ferr_q <= accept && !frame_good;
  end
`else
  assign frame_good = 1'b1;
  assign ferr       = 1'b0;
`endif

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state != IDLE),
    .clr    (state == IDLE),
    .tick   (bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    unique case (state)
      IDLE:  if (accept && frame_good) begin
               state_d = SHIFT;
               load    = 1'b1;
             end
      SHIFT: if (last_bit) state_d = (GAP_BITS > 0) ? GAP : IDLE;
      GAP:   if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the frame register is reset too; it is only 10 flops and keeps txd defined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '1;
      txd     <= STOP_BIT;
      iready  <= 1'b0;
      bit_idx <= '0;
      gap_cnt <= '0;
    end else begin
      // Dropping on the accept edge forbids back-to-back frames and completes a rejected handshake.
      iready <= (state_d == IDLE) && !accept;

      if (load) begin
        shreg   <= idata;
        txd     <= idata[0];
        bit_idx <= '0;
      end else if (state == SHIFT && bit_tick) begin
        shreg   <= {STOP_BIT, shreg[FRAME_W-1:1]};
        txd     <= last_bit ? STOP_BIT : shreg[1];
        bit_idx <= last_bit ? 4'd0 : bit_idx + 4'd1;
      end

      if (state == GAP) begin
        if (bit_tick) gap_cnt <= gap_cnt + GW'(CLKS_PER_BIT);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule
